// File: rtl/rx_frame_fsm.sv
// Parametrised UART receive framer with mid-bit oversampled sampling and per-frame error flags.
// Define RX_BREAK_DETECT_EN to add the break_detected output and break handling.
module rx_frame_fsm #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  os_tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy,
  output logic [2:0]            state
`ifdef RX_BREAK_DETECT_EN
  ,
  output logic                  break_detected
`endif
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [OS_W-1:0]  START_PT  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  BIT_PT    = OS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_prev;
  logic [OS_W-1:0]         os_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    par_err, fr_err, break_wait;
  logic                    fall_edge, start_pt, bit_pt, brk_hit;
`ifdef RX_BREAK_DETECT_EN
  logic                    par_bit;
`endif

  assign fall_edge = ~rx_in & rx_prev;
  assign start_pt  = os_tick && (os_cnt == START_PT);
  assign bit_pt    = os_tick && (os_cnt == BIT_PT);

  // A break is judged at the first stop sample: everything since the start bit was low.
`ifdef RX_BREAK_DETECT_EN
  assign brk_hit = (state_q == STOP) && !break_wait && bit_pt && (bit_idx == '0) && !rx_in &&
                   (shift_reg == '0) && ((PARITY_MODE == 0) || !par_bit);
`else
  assign brk_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (fall_edge) state_d = START;
      START:  if (start_pt) state_d = rx_in ? IDLE : DATA;
      DATA:   if (bit_pt && (bit_idx == LAST_DATA)) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY: if (bit_pt) state_d = STOP;
      STOP: begin
        if (break_wait) begin
          if (os_tick && rx_in) state_d = IDLE;
        end else if (bit_pt && (bit_idx == LAST_STOP) && !brk_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    state = state_q;
  end

  // Sampling datapath; completion outputs are single-cycle and zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev       <= 1'b1;
      os_cnt        <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      par_err       <= 1'b0;
      fr_err        <= 1'b0;
      break_wait    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      par_bit        <= 1'b0;
      break_detected <= 1'b0;
`endif
    end else begin
      rx_prev       <= rx_in;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      break_detected <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          os_cnt     <= '0;
          bit_idx    <= '0;
          break_wait <= 1'b0;
        end
        START: begin
          if (start_pt) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            par_err <= 1'b0;
            fr_err  <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
            par_bit <= 1'b0;
`endif
          end else if (os_tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_pt) begin
            os_cnt    <= '0;
            shift_reg <= {rx_in, shift_reg[DATA_WIDTH-1:1]};
            bit_idx   <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 1'b1;
          end else if (os_tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_pt) begin
            os_cnt  <= '0;
            par_err <= ((^shift_reg) ^ rx_in) ^ (PARITY_MODE == 2);
`ifdef RX_BREAK_DETECT_EN
            par_bit <= rx_in;
`endif
          end else if (os_tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        STOP: begin
          if (break_wait) begin
            if (os_tick && rx_in) break_wait <= 1'b0;
          end else if (bit_pt) begin
            os_cnt <= '0;
            if (brk_hit) begin
              break_wait <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
              break_detected <= 1'b1;
`endif
            end else if (bit_idx == LAST_STOP) begin
              rx_valid      <= 1'b1;
              rx_data       <= shift_reg;
              parity_error  <= (PARITY_MODE != 0) && par_err;
              framing_error <= fr_err | ~rx_in;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              fr_err  <= fr_err | ~rx_in;
            end
          end else if (os_tick) begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        default: begin
          os_cnt  <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule
